iter_radix4_booth_mul: RTL and testbench

Iterative unsigned multiplier that time-shares a single radix-4 Booth partial-product stage. It computes one Booth digit and accumulates one partial product per cycle. It sits in the multiplier subtree as the area-reduced alternative to the fully parallel Booth array, for low-throughput fraction multiplies in the posit FMA path. A valid/ready handshake is used on both the operand and the result side.

---
 rtl/iter_radix4_booth_mul.sv | 119 +++++++++++
 tb/tb_iter_radix4_booth_mul.sv | 139 +++++++++++++
 2 files changed

// File: rtl/iter_radix4_booth_mul.sv
// Iterative unsigned multiplier built around one shared radix-4 Booth partial-product stage.
// Each RUN cycle retires one Booth digit. Results are exchanged through valid/ready handshakes.
module iter_radix4_booth_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int N    = WIDTH / 2 + 1;
  localparam int ACCW = 2 * WIDTH + 2;
  localparam int CW   = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH+2:0] mplier_q, mplier_d;
  logic [ACCW-1:0]  acc_q, acc_d;
  logic [CW-1:0]    step_q, step_d;

  logic [ACCW-1:0]  mag;
  logic [ACCW-1:0]  pp;
  logic [ACCW-1:0]  inj;
  logic             neg;
  logic [CW:0]      shamt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      step_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      step_q   <= step_d;
    end
  end

  // The multiplier register shifts right two bits per step, so bits [2:0] always hold the current digit window
  always_comb begin
    mag = '0;
    neg = 1'b0;
    unique case (mplier_q[2:0])
      3'b001, 3'b010: mag = {{(ACCW-WIDTH){1'b0}}, mcand_q};
      3'b011:         mag = {{(ACCW-WIDTH-1){1'b0}}, mcand_q, 1'b0};
      3'b100: begin
        mag = {{(ACCW-WIDTH-1){1'b0}}, mcand_q, 1'b0};
        neg = 1'b1;
      end
      3'b101, 3'b110: begin
        mag = {{(ACCW-WIDTH){1'b0}}, mcand_q};
        neg = 1'b1;
      end
      default: begin
        mag = '0;
        neg = 1'b0;
      end
    endcase
  end

  // Negative digits use the inverted magnitude; the +1 is injected at bit 2i to complete the two's complement
  always_comb begin
    shamt = {step_q, 1'b0};
    pp    = (neg ? ~mag : mag) << shamt;
    inj   = ACCW'(neg) << shamt;
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    step_d   = step_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = a;
          mplier_d = {2'b00, b, 1'b0};
          acc_d    = '0;
          step_d   = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = acc_q + pp + inj;
        mplier_d = {2'b00, mplier_q[WIDTH+2:2]};
        step_d   = step_q + 1'b1;
        if (step_q == CW'(N - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign product   = acc_q[2*WIDTH-1:0];

endmodule

// File: tb/tb_iter_radix4_booth_mul.sv
// Directed bench for iter_radix4_booth_mul at WIDTH=8: latency, backpressure, mid-run reset,
// ignored in_valid during RUN, and hand-computed products.
module tb_iter_radix4_booth_mul;

  localparam int WIDTH = 8;
  localparam int LAT   = WIDTH / 2 + 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  int checks   = 0;
  int failures = 0;

  iter_radix4_booth_mul #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One full transaction; optionally holds out_ready low, pulses in_valid mid-run, or resets mid-run
  task automatic applyStimulus(input logic [7:0] aV, input logic [7:0] bV, input logic [15:0] expProd,
                               input int holdLow, input bit glitch, input bit midReset, input string tag);
    int cnt;
    @(negedge clk);
    in_valid  = 1'b1;
    a         = aV;
    b         = bV;
    out_ready = (holdLow == 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a        = ~aV;
    b        = ~bV;
    checkOutput({tag, "_inready_run"}, 32'(in_ready), 32'd0);
    checkOutput({tag, "_busy_run"}, 32'(busy), 32'd1);
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      if (glitch && cnt == 2) begin
        in_valid = 1'b1;
        a        = 8'h11;
        b        = 8'h22;
      end else begin
        in_valid = 1'b0;
      end
      if (midReset && cnt == 2) begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput({tag, "_rst_inready"}, 32'(in_ready), 32'd1);
        checkOutput({tag, "_rst_outvalid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_rst_product"}, 32'(product), 32'd0);
        checkOutput({tag, "_rst_busy"}, 32'(busy), 32'd0);
        return;
      end
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput({tag, "_latency"}, 32'(cnt), 32'(LAT));
    checkOutput({tag, "_product"}, 32'(product), 32'(expProd));
    checkOutput({tag, "_inready_done"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < holdLow; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, "_hold_outvalid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, "_hold_product"}, 32'(product), 32'(expProd));
      checkOutput({tag, "_hold_inready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_post_inready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, "_post_outvalid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_post_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_inready", 32'(in_ready), 32'd1);
    checkOutput("reset_outvalid", 32'(out_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_product", 32'(product), 32'd0);
    rst = 1'b0;

    applyStimulus(8'hFF, 8'hFF, 16'hFE01, 0, 1'b0, 1'b0, "ffxff");
    applyStimulus(8'h00, 8'hAA, 16'h0000, 0, 1'b0, 1'b0, "zero_a");
    applyStimulus(8'hB7, 8'h00, 16'h0000, 0, 1'b0, 1'b0, "zero_b");
    applyStimulus(8'h5A, 8'hAA, 16'h3BC4, 10, 1'b0, 1'b0, "backpressure");
    applyStimulus(8'hC3, 8'h7E, 16'h0000, 0, 1'b0, 1'b1, "midreset");
    applyStimulus(8'h03, 8'h05, 16'h000F, 0, 1'b0, 1'b0, "after_reset");
    applyStimulus(8'h12, 8'h34, 16'h03A8, 0, 1'b1, 1'b0, "glitch");
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      checkOutput("no_second_result", 32'(out_valid), 32'd0);
    end
    applyStimulus(8'h80, 8'h80, 16'h4000, 0, 1'b0, 1'b0, "80x80");
    applyStimulus(8'h01, 8'hFF, 16'h00FF, 2, 1'b0, 1'b0, "01xff");
    applyStimulus(8'hFF, 8'h01, 16'h00FF, 0, 1'b0, 1'b0, "ffx01");
    applyStimulus(8'hAB, 8'hCD, 16'h88EF, 1, 1'b0, 1'b0, "abxcd");
    applyStimulus(8'h7F, 8'h80, 16'h3F80, 0, 1'b0, 1'b0, "7fx80");
    applyStimulus(8'h55, 8'h55, 16'h1C39, 0, 1'b0, 1'b0, "55x55");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
